// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - round-robin note-to-voice allocator with valid/ready intake
// Optional VOICE_STEAL_EN: when no voice is free, re-grant the oldest sounding voice.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  play_i,
  input  logic                  flush_i,
  input  logic                  note_valid_i,
  input  logic [NOTE_W-1:0]     note_in_i,
  input  logic [DUR_W-1:0]      dur_in_i,
  output logic                  note_ready_o,
  input  logic [NUM_VOICES-1:0] voice_done_i,
  output logic [NUM_VOICES-1:0] load_voice_o,
  output logic [NOTE_W-1:0]     voice_note_o,
  output logic [DUR_W-1:0]      voice_dur_o,
  output logic [NUM_VOICES-1:0] active_o
);
  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_VOICES-1:0] load_voice_q, load_voice_d;
  logic [NOTE_W-1:0]     voice_note_q, voice_note_d;
  logic [DUR_W-1:0]      voice_dur_q, voice_dur_d;

  logic [NUM_VOICES-1:0] free;
  logic                  any_free;
  logic                  accept;
  logic                  rr_found;
  logic [PTR_W-1:0]      rr_target;
  logic [PTR_W-1:0]      target;
  logic [PTR_W:0]        probe;

  assign free     = ~active_q;
  assign any_free = |free;

  // Scan upward from rr_ptr, wrapping at NUM_VOICES-1, for the first free voice.
  always_comb begin
    rr_found  = 1'b0;
    rr_target = '0;
    probe     = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      probe = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (probe >= (PTR_W+1)'(NUM_VOICES)) begin
        probe = probe - (PTR_W+1)'(NUM_VOICES);
      end
      if (!rr_found && free[probe[PTR_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_target = probe[PTR_W-1:0];
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [DUR_W-1:0] age_q [NUM_VOICES];
  logic [DUR_W-1:0] age_d [NUM_VOICES];
  logic [DUR_W-1:0] oldest_age;
  logic [PTR_W-1:0] oldest;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    oldest     = '0;
    oldest_age = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > oldest_age) begin
        oldest     = PTR_W'(i);
        oldest_age = age_q[i];
      end
    end
  end

  assign note_ready_o = play_i & ~flush_i & ~reset_i;
  assign target       = any_free ? rr_target : oldest;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_d[i] = age_q[i];
      if (play_i && active_q[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
      if (accept && (target == PTR_W'(i))) begin
        age_d[i] = '0;
      end
      if (flush_i) begin
        age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  assign note_ready_o = play_i & ~flush_i & ~reset_i & any_free;
  assign target       = rr_target;
`endif

  assign accept = note_valid_i & note_ready_o;

  // A steal forces the target bit back on, so a same-cycle done on it is ignored.
  always_comb begin
    active_d     = active_q & ~voice_done_i;
    rr_ptr_d     = rr_ptr_q;
    load_voice_d = '0;
    voice_note_d = voice_note_q;
    voice_dur_d  = voice_dur_q;
    if (accept) begin
      active_d[target]     = 1'b1;
      load_voice_d[target] = 1'b1;
      voice_note_d         = note_in_i;
      voice_dur_d          = dur_in_i;
      if (any_free) begin
        rr_ptr_d = (target == PTR_W'(NUM_VOICES-1)) ? '0 : target + 1'b1;
      end
    end
    if (flush_i) begin
      active_d     = '0;
      rr_ptr_d     = '0;
      load_voice_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q     <= '0;
      rr_ptr_q     <= '0;
      load_voice_q <= '0;
      voice_note_q <= '0;
      voice_dur_q  <= '0;
    end else begin
      active_q     <= active_d;
      rr_ptr_q     <= rr_ptr_d;
      load_voice_q <= load_voice_d;
      voice_note_q <= voice_note_d;
      voice_dur_q  <= voice_dur_d;
    end
  end

  assign load_voice_o = load_voice_q;
  assign voice_note_o = voice_note_q;
  assign voice_dur_o  = voice_dur_q;
  assign active_o     = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed + randomized check of voice_allocator against an array-based model
module tb_voice_allocator;
  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int AGE_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset, play, flush, note_valid;
  logic [NW-1:0] note_in;
  logic [DW-1:0] dur_in;
  logic          note_ready;
  logic [NV-1:0] voice_done, load_voice, active;
  logic [NW-1:0] voice_note;
  logic [DW-1:0] voice_dur;

  int total = 0;
  int bad   = 0;

  bit m_act [NV];
  int m_age [NV];
  int m_rr   = 0;
  int m_load = 0;
  int m_note = 0;
  int m_dur  = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .play_i       (play),
    .flush_i      (flush),
    .note_valid_i (note_valid),
    .note_in_i    (note_in),
    .dur_in_i     (dur_in),
    .note_ready_o (note_ready),
    .voice_done_i (voice_done),
    .load_voice_o (load_voice),
    .voice_note_o (voice_note),
    .voice_dur_o  (voice_dur),
    .active_o     (active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_any_free();
    bit f = 1'b0;
    for (int k = 0; k < NV; k++) if (!m_act[k]) f = 1'b1;
    return f;
  endfunction

  function automatic bit m_ready(input bit r, input bit p, input bit f);
`ifdef VOICE_STEAL_EN
    return p && !f && !r;
`else
    return p && !f && !r && m_any_free();
`endif
  endfunction

  function automatic int m_act_vec();
    int v = 0;
    for (int k = 0; k < NV; k++) if (m_act[k]) v |= (1 << k);
    return v;
  endfunction

  // One clock: drive, check ready before the edge, advance the model, check registered outputs.
  task automatic step(input bit r, input bit p, input bit f, input bit v,
                      input int n, input int d, input int done);
    bit acc, stole, found;
    int tgt;
    reset = r; play = p; flush = f; note_valid = v;
    note_in = NW'(n); dur_in = DW'(d); voice_done = NV'(done);
    #1;
    check("note_ready", 32'(note_ready), 32'(m_ready(r, p, f)));
    acc   = v && m_ready(r, p, f);
    stole = acc && !m_any_free();
    tgt   = 0;
    found = 1'b0;
    for (int k = 0; k < NV; k++) begin
      if (!found && !m_act[(m_rr + k) % NV]) begin
        found = 1'b1;
        tgt   = (m_rr + k) % NV;
      end
    end
    if (stole) begin
      tgt = 0;
      for (int k = 1; k < NV; k++) if (m_age[k] > m_age[tgt]) tgt = k;
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < NV; k++) begin m_act[k] = 1'b0; m_age[k] = 0; end
      m_rr = 0; m_load = 0; m_note = 0; m_dur = 0;
    end else if (f) begin
      for (int k = 0; k < NV; k++) begin m_act[k] = 1'b0; m_age[k] = 0; end
      m_rr = 0; m_load = 0;
    end else begin
      for (int k = 0; k < NV; k++) begin
        if (p && m_act[k] && m_age[k] < AGE_MAX) m_age[k]++;
        if (done[k]) m_act[k] = 1'b0;
      end
      m_load = 0;
      if (acc) begin
        m_act[tgt] = 1'b1;
        m_age[tgt] = 0;
        m_load     = 1 << tgt;
        m_note     = n;
        m_dur      = d;
        if (!stole) m_rr = (tgt + 1) % NV;
      end
    end
    check("load_voice", 32'(load_voice), 32'(m_load));
    check("voice_note", 32'(voice_note), 32'(m_note));
    check("voice_dur",  32'(voice_dur),  32'(m_dur));
    check("active",     32'(active),     32'(m_act_vec()));
  endtask

  initial begin
    bit pv, r, p, f, will_acc;
    int pn, pd, dn;
    for (int k = 0; k < NV; k++) begin m_act[k] = 1'b0; m_age[k] = 0; end

    step(1, 1, 0, 1, 5, 5, 0);
    check("reset_ready_low", 32'(note_ready), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("idle_active", 32'(active), 32'd0);
    #0 check("idle_ready", 32'(note_ready), 32'd1);

    step(0, 1, 0, 1, 10, 4, 0);
    check("fill0_load", 32'(load_voice), 32'b001);
    check("fill0_note", 32'(voice_note), 32'd10);
    step(0, 1, 0, 1, 20, 5, 0);
    check("fill1_load", 32'(load_voice), 32'b010);
    step(0, 1, 0, 1, 30, 6, 0);
    check("fill2_load", 32'(load_voice), 32'b100);
    check("fill2_dur",  32'(voice_dur),  32'd6);
    check("fill_active", 32'(active), 32'b111);

`ifndef VOICE_STEAL_EN
    step(0, 1, 0, 1, 40, 7, 0);
    check("stall_load", 32'(load_voice), 32'd0);
    step(0, 1, 0, 1, 40, 7, 3'b010);
    check("stall_done_load", 32'(load_voice), 32'd0);
    step(0, 1, 0, 1, 40, 7, 0);
    check("release_load", 32'(load_voice), 32'b010);
    check("release_note", 32'(voice_note), 32'd40);
    step(0, 1, 0, 0, 0, 0, 3'b101);
    step(0, 1, 0, 1, 41, 2, 0);
    check("rr_after_release", 32'(load_voice), 32'b100);

    step(0, 0, 0, 1, 33, 1, 3'b010);
    check("pause_load", 32'(load_voice), 32'd0);
    check("pause_active", 32'(active), 32'b100);

    step(0, 1, 1, 1, 42, 3, 3'b100);
    check("flush_load", 32'(load_voice), 32'd0);
    check("flush_active", 32'(active), 32'd0);
    step(0, 1, 0, 1, 43, 3, 0);
    check("flush_rr_zero", 32'(load_voice), 32'b001);
`else
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 50, 9, 0);
    check("steal_load", 32'(load_voice), 32'b001);
    check("steal_note", 32'(voice_note), 32'd50);
    check("steal_active", 32'(active), 32'b111);
`endif

    pv = 1'b0; pn = 0; pd = 0;
    repeat (400) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pn = int'($urandom_range(0, 63));
        pd = int'($urandom_range(0, 63));
      end
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 9) != 0);
      dn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
      will_acc = pv && m_ready(r, p, f);
      step(r, p, f, pv, pn, pd, dn);
      if (will_acc) pv = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
